clk_div_checker: RTL and testbench

//   Downstream self-test stage for the clock-divider block. Samples its divided taps
//   (div2/4/8/16) in the source clk domain and counts rising edges per tap over a fixed window.

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_checker_if.sv | 21 ++
 rtl/tap_edge_counter.sv | 45 ++++
 rtl/clk_div_checker.sv | 73 +++++++
 tb/tb_clk_div_checker.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults, FSM state type and ideal per-tap edge count
package clk_div_pkg;
  localparam int DEF_NUM_TAPS = 4;
  localparam int DEF_WIN_LOG2 = 6;
  localparam int DEF_TOL = 1;
  typedef enum logic [1:0] {IDLE, MEAS, EVAL} state_t;
  function automatic int expected_count(input int i, input int win_log2);
    return 1 << (win_log2 - i - 1);
  endfunction
endpackage

// File: rtl/clk_div_checker_if.sv
// clk_div_checker_if: control/result bundle between a test controller (master) and the checker (slave)
// master drives start, clear, taps, cnt_sel; slave returns busy, done, pass, fail_sticky, cnt_out
interface clk_div_checker_if
  import clk_div_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
);
  localparam int SEL_W = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
  logic start;
  logic clear;
  logic [NUM_TAPS-1:0] taps;
  logic [SEL_W-1:0] cnt_sel;
  logic busy;
  logic done;
  logic [NUM_TAPS-1:0] pass;
  logic fail_sticky;
  logic [WIN_LOG2-1:0] cnt_out;
  modport master(output start, clear, taps, cnt_sel, input busy, done, pass, fail_sticky, cnt_out);
  modport slave(input start, clear, taps, cnt_sel, output busy, done, pass, fail_sticky, cnt_out);
endinterface

// File: rtl/tap_edge_counter.sv
// tap_edge_counter: rising-edge counter for one divider tap with tolerance check against its ideal count
// clk/reset: clock and sync active-high reset; i_start clears the count; i_meas enables counting;
// i_eval latches o_ok into o_pass; i_tap is the tap; o_cnt is the held/live count
module tap_edge_counter #(
  parameter int CNT_W = 6,
  parameter int EXP = 1,
  parameter int TOL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_meas,
  input  logic             i_eval,
  input  logic             i_tap,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ok,
  output logic             o_pass
);
  logic r_tap_q;
  logic r_pass;
  logic [CNT_W-1:0] r_cnt;
  logic w_rise;
  logic [CNT_W:0] w_cnt_x;
  logic [CNT_W:0] w_exp;
  logic [CNT_W:0] w_diff;
  assign w_rise = i_tap & ~r_tap_q;
  assign w_cnt_x = {1'b0, r_cnt};
  assign w_exp = (CNT_W + 1)'(EXP);
  // extra bit keeps the absolute difference exact without signed arithmetic
  assign w_diff = w_cnt_x >= w_exp ? w_cnt_x - w_exp : w_exp - w_cnt_x;
  assign o_ok = w_diff <= (CNT_W + 1)'(TOL);
  assign o_cnt = r_cnt;
  assign o_pass = r_pass;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tap_q <= 1'b0;
      r_cnt <= '0;
      r_pass <= 1'b0;
    end else begin
      r_tap_q <= i_tap;
      r_cnt <= i_start ? '0 : (i_meas && w_rise && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
      r_pass <= i_eval ? o_ok : r_pass;
    end
  end
endmodule

// File: rtl/clk_div_checker.sv
// clk_div_checker: counts divider-tap rising edges over a 2^WIN_LOG2-cycle window and reports per-tap pass
// clk: system clock; reset: sync active-high; bus: slave side of clk_div_checker_if
module clk_div_checker
  import clk_div_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int TOL = DEF_TOL
) (
  input  logic clk,
  input  logic reset,
  clk_div_checker_if.slave bus
);
  state_t r_state;
  state_t w_next;
  logic [WIN_LOG2-1:0] r_win;
  logic r_busy;
  logic r_done;
  logic r_fail;
  logic w_start;
  logic w_meas;
  logic w_eval;
  logic [NUM_TAPS-1:0] w_ok;
  logic [NUM_TAPS-1:0] w_pass;
  logic [WIN_LOG2-1:0] w_cnt [NUM_TAPS];
  assign w_start = r_state == IDLE && bus.start;
  assign w_meas = r_state == MEAS;
  assign w_eval = r_state == EVAL;
  // window length is a power of two, so the last MEAS cycle is r_win all-ones
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (bus.start ? MEAS : IDLE) :
             r_state == MEAS ? (&r_win ? EVAL : MEAS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_win <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_state <= w_next;
      r_win <= w_start ? '0 : w_meas ? r_win + WIN_LOG2'(1) : r_win;
      r_busy <= w_start ? 1'b1 : w_eval ? 1'b0 : r_busy;
      r_done <= w_eval;
      // a failing evaluation overrides a coincident clear
      r_fail <= (w_eval && !(&w_ok)) ? 1'b1 : bus.clear ? 1'b0 : r_fail;
    end
  end
  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    tap_edge_counter #(
      .CNT_W(WIN_LOG2),
      .EXP(expected_count(g, WIN_LOG2)),
      .TOL(TOL)
    ) u_tap (
      .clk(clk),
      .reset(reset),
      .i_start(w_start),
      .i_meas(w_meas),
      .i_eval(w_eval),
      .i_tap(bus.taps[g]),
      .o_cnt(w_cnt[g]),
      .o_ok(w_ok[g]),
      .o_pass(w_pass[g])
    );
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = w_pass;
  assign bus.fail_sticky = r_fail;
  assign bus.cnt_out = w_cnt[bus.cnt_sel];
endmodule

// File: tb/tb_clk_div_checker.sv
// tb_clk_div_checker: directed + randomized self-checking bench against a window edge-count model
module tb_clk_div_checker;
  localparam int N = 4;
  localparam int WL = 6;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int mode = 0;
  int phase = 0;
  int unsigned free_c = 0;
  bit model_fail = 0;
  logic [N-1:0] hist[$];
  always #5 clk = ~clk;
  clk_div_checker_if #(.NUM_TAPS(N), .WIN_LOG2(WL)) bus ();
  clk_div_checker #(.NUM_TAPS(N), .WIN_LOG2(WL), .TOL(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // mode 0 ideal divider, 1 tap2 stuck low, 2 tap3 at div8 rate, 3 random toggling
  function automatic logic [N-1:0] gen();
    logic [31:0] c;
    c = free_c + 32'(phase);
    case (mode)
      0: return c[3:0];
      1: return c[3:0] & 4'b1011;
      2: return {c[2], c[2:0]};
      default: return 4'($urandom);
    endcase
  endfunction
  task automatic tick();
    logic [N-1:0] t;
    t = gen();
    bus.taps = t;
    hist.push_back(t);
    @(posedge clk);
    #1;
    free_c++;
  endtask
  // rising edges of tap i among the W+1 samples seen from the start edge onward
  function automatic int model_cnt(input int i);
    int c = 0;
    for (int j = 1; j <= W; j++) if (hist[j][i] && !hist[j-1][i]) c++;
    return c;
  endfunction
  function automatic logic [N-1:0] model_pass();
    logic [N-1:0] p;
    int d;
    for (int i = 0; i < N; i++) begin
      d = model_cnt(i) - (W >> (i + 1));
      p[i] = (d <= 1 && d >= -1);
    end
    return p;
  endfunction
  task automatic run(input bit rep, input bit clr_eval, input int abort_at, output int lat);
    hist.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    chk("busy_after_start", 32'(bus.busy), 1);
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      bus.start = rep && (n == 10 || n == 40);
      bus.clear = clr_eval && n == W + 1;
      reset = abort_at != 0 && n >= abort_at && n < abort_at + 3;
      tick();
      if (bus.done) lat = n;
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
    reset = 1'b0;
  endtask
  task automatic check_run(input string tag, input bit clr_eval);
    logic [N-1:0] mp;
    mp = model_pass();
    if (!(&mp)) model_fail = 1;
    else if (clr_eval) model_fail = 0;
    chk({tag, "_pass"}, 32'(bus.pass), 32'(mp));
    chk({tag, "_sticky"}, 32'(bus.fail_sticky), 32'(model_fail));
    for (int i = 0; i < N; i++) begin
      bus.cnt_sel = 2'(i);
      #1;
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bus.cnt_out), 32'(model_cnt(i)));
    end
  endtask
  task automatic clear_pulse();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_fail = 0;
    chk("clear_sticky", 32'(bus.fail_sticky), 0);
  endtask
  initial begin
    int lat;
    int d1;
    int d2;
    int nd;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.cnt_sel = '0;
    bus.taps = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_sticky", 32'(bus.fail_sticky), 0);
    chk("rst_cnt", 32'(bus.cnt_out), 0);
    reset = 1'b0;
    tick();
    run(0, 0, 0, lat);
    chk("ideal_lat", 32'(lat), 65);
    chk("ideal_pass_const", 32'(bus.pass), 32'hF);
    for (int i = 0; i < N; i++) begin
      bus.cnt_sel = 2'(i);
      #1;
      chk($sformatf("ideal_const_cnt%0d", i), 32'(bus.cnt_out), 32'(32 >> i));
    end
    check_run("ideal", 0);
    tick();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_idle", 32'(bus.busy), 0);
    mode = 1;
    run(0, 0, 0, lat);
    chk("stuck_lat", 32'(lat), 65);
    chk("stuck_pass_const", 32'(bus.pass), 32'b1011);
    check_run("stuck", 0);
    mode = 0;
    run(0, 0, 0, lat);
    check_run("good_after_fail", 0);
    chk("sticky_held", 32'(bus.fail_sticky), 1);
    clear_pulse();
    mode = 2;
    run(0, 0, 0, lat);
    check_run("div8_on_tap3", 0);
    chk("div8_pass3", 32'(bus.pass[3]), 0);
    clear_pulse();
    mode = 0;
    for (int p = 1; p < 16; p++) begin
      phase = p;
      run(0, 0, 0, lat);
      check_run($sformatf("phase%0d", p), 0);
    end
    phase = 0;
    run(1, 0, 0, lat);
    chk("repulse_lat", 32'(lat), 65);
    tick();
    chk("repulse_no_second_done", 32'(bus.done), 0);
    repeat (70) begin
      tick();
      if (bus.done) chk("repulse_extra_done", 32'(bus.done), 0);
    end
    hist.delete();
    bus.start = 1'b1;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int n = 0; n < 200 && nd < 2; n++) begin
      tick();
      if (bus.done) begin
        if (nd == 0) d1 = n;
        else d2 = n;
        nd++;
      end
    end
    bus.start = 1'b0;
    chk("held_first_done", 32'(d1), 65);
    chk("held_period", 32'(d2 - d1), 66);
    tick();
    chk("held_stop_busy", 32'(bus.busy), 0);
    mode = 1;
    run(0, 1, 0, lat);
    check_run("clear_vs_fail", 1);
    chk("clear_vs_fail_const", 32'(bus.fail_sticky), 1);
    mode = 0;
    clear_pulse();
    mode = 1;
    run(0, 0, 0, lat);
    check_run("pre_abort_fail", 0);
    mode = 0;
    run(0, 0, 30, lat);
    model_fail = 0;
    chk("abort_no_done", 32'(lat), 32'(-1));
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_pass", 32'(bus.pass), 0);
    chk("abort_sticky", 32'(bus.fail_sticky), 0);
    chk("abort_cnt", 32'(bus.cnt_out), 0);
    mode = 3;
    for (int r = 0; r < 4; r++) begin
      run(0, 0, 0, lat);
      chk($sformatf("rand%0d_lat", r), 32'(lat), 65);
      check_run($sformatf("rand%0d", r), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
